fetch_ctrl: RTL and testbench

//  Fetch sequencer for the dual-issue front end. Owns the PC and drives the word address of the
//  2-wide instruction ROM, which has 1-cycle registered read latency. Tags each returned pair with
//  its PC and buffers it in a small fetch queue. Presents pairs to decode with a valid/ready

---
 rtl/fetch_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the dual-issue front end.
// Owns the PC and drives the word address of a 2-wide ROM with a 1-cycle registered read.
// Each returned pair is tagged with the PC that fetched it and pushed into a small circular
// fetch queue. The head of the queue is offered to decode through a valid/ready handshake.
// A redirect flushes the queue, kills the read in flight and restarts fetch at the new PC.
module fetch_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned FQ_DEPTH = 4,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // instruction ROM
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [31:0]                rom_instr1,
    input  logic [31:0]                rom_instr2,
    // redirect from branch/JAL resolution
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    // decode handshake
    input  logic                       dec_ready,
    output logic                       out_valid,
    output logic [31:0]                out_instr1,
    output logic [31:0]                out_instr2,
    output logic [31:0]                out_pc,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // PC byte space is 2^(ADDR_W+2); increments wrap inside it
    localparam logic [31:0] PC_MASK = 32'((64'd1 << (ADDR_W + 2)) - 64'd1);
    localparam logic [31:0] PC_STEP = 32'd8;
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;

    // Last ROM word: its younger slot would read past the end of the ROM
    localparam logic [ADDR_W-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StRedir
    } state_e;

    // ------------------------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------------------------
    state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;

    // 1-deep in-flight tracker: set the cycle after an issue, holds the issued PC
    logic        inflight_q, inflight_d;
    logic [31:0] tag_pc_q, tag_pc_d;

    // Queue storage and bookkeeping
    logic [31:0] fq_instr1 [FQ_DEPTH];
    logic [31:0] fq_instr2 [FQ_DEPTH];
    logic [31:0] fq_pc     [FQ_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             issue;
    logic             credit_ok;
    logic [CNT_W:0]   credits_used;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [31:0]      slot2;

    // ------------------------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: redirect overrides everything, otherwise every state settles into StRun
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = StRedir;
        end else begin
            unique case (state_q)
                StBoot:  state_d = StRun;
                StRun:   state_d = StRun;
                StRedir: state_d = StRun;
                default: state_d = StBoot;
            endcase
        end
    end

    // Credit check counts the queued pairs plus the one that may still be returning from ROM
    always_comb begin
        credits_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        credit_ok    = (credits_used < (CNT_W + 1)'(FQ_DEPTH));
    end

    // FSM output: issue a ROM read only in StRun with credit and no redirect this cycle
    always_comb begin
        issue = 1'b0;
        if ((state_q == StRun) && credit_ok && !redirect_valid) begin
            issue = 1'b1;
        end
    end

    // ------------------------------------------------------------------------------------------
    // PC and in-flight tracking
    // ------------------------------------------------------------------------------------------

    // Next PC and in-flight tag
    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        tag_pc_d   = tag_pc_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc & ALIGN;
            inflight_d = 1'b0;
        end else if (issue) begin
            pc_d     = (pc_q + PC_STEP) & PC_MASK;
            tag_pc_d = pc_q;
        end
    end

    // PC and in-flight registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC & ALIGN;
            inflight_q <= 1'b0;
            tag_pc_q   <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_pc_q   <= tag_pc_d;
        end
    end

    assign rom_addr = pc_q[ADDR_W+1:2];

    // ------------------------------------------------------------------------------------------
    // Fetch queue
    // ------------------------------------------------------------------------------------------

    // Push the returning pair unless a redirect kills it; pop only a valid head
    always_comb begin
        head_valid = (count_q != '0);
        push       = inflight_q && !redirect_valid;
        pop        = head_valid && dec_ready && !redirect_valid;
        slot2      = (tag_pc_q[ADDR_W+1:2] == LAST_WORD) ? NOP : rom_instr2;
    end

    // Pointer and occupancy update; a redirect empties the queue outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are only observed through a valid head so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fq_instr1[wr_ptr_q] <= rom_instr1;
            fq_instr2[wr_ptr_q] <= slot2;
            fq_pc[wr_ptr_q]     <= tag_pc_q;
        end
    end

    // Head presentation; forced to the idle values when empty so reset outputs are defined
    always_comb begin
        out_valid  = head_valid;
        out_instr1 = NOP;
        out_instr2 = NOP;
        out_pc     = 32'h0;
        if (head_valid) begin
            out_instr1 = fq_instr1[rd_ptr_q];
            out_instr2 = fq_instr2[rd_ptr_q];
            out_pc     = fq_pc[rd_ptr_q];
        end
    end

    assign fq_count = count_q;

`ifndef SYNTHESIS
    // The credit rule must keep every push away from a full queue
    push_not_full_a : assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q < CNT_W'(FQ_DEPTH)));
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot timing, back-pressure, redirects, ROM-end wrap guard
// and asynchronous reset in mid-stream.
module tb_fetch_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] rom_addr_nxt;
    logic [31:0]       rom_instr1;
    logic [31:0]       rom_instr2;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              dec_ready;
    logic              out_valid;
    logic [31:0]       out_instr1;
    logic [31:0]       out_instr2;
    logic [31:0]       out_pc;
    logic [2:0]        fq_count;

    int n_checks;
    int n_fail;

    logic [31:0] rom_mem [1 << ADDR_W];

    fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0),
        .FQ_DEPTH (4),
        .NOP      (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_instr1     (rom_instr1),
        .rom_instr2     (rom_instr2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .out_valid      (out_valid),
        .out_instr1     (out_instr1),
        .out_instr2     (out_instr2),
        .out_pc         (out_pc),
        .fq_count       (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, recognisable word per ROM index
    function automatic logic [31:0] rom_word(input int unsigned idx);
        return 32'hA500_0000 | (idx & 32'h3FF);
    endfunction

    // Registered 2-wide ROM; the second port wraps at the top of the address space
    assign rom_addr_nxt = rom_addr + 10'd1;
    always @(posedge clk) begin
        rom_instr1 <= rom_mem[rom_addr];
        rom_instr2 <= rom_mem[rom_addr_nxt];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected head pair fetched from byte address pc
    task automatic expect_pair(input string tag, input logic [31:0] pc);
        int unsigned w;
        logic [31:0] exp2;
        w    = (pc >> 2) & 32'h3FF;
        exp2 = (w == 1023) ? NOP : rom_word(w + 1);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " pc"},    out_pc,         pc);
        check({tag, " i1"},    out_instr1,     rom_word(w));
        check({tag, " i2"},    out_instr2,     exp2);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " valid"}, 32'(out_valid),  32'd0);
        check({tag, " i1"},    out_instr1,      NOP);
        check({tag, " i2"},    out_instr2,      NOP);
        check({tag, " pc"},    out_pc,          32'h0);
        check({tag, " cnt"},   32'(fq_count),   32'd0);
    endtask

    // Called right after rst_n release; dec_ready is expected high
    task automatic boot_check(input string tag);
        tick();
        check({tag, " e1 valid"}, 32'(out_valid), 32'd0);
        check({tag, " e1 addr"},  32'(rom_addr),  32'd0);
        tick();
        check({tag, " e2 valid"}, 32'(out_valid), 32'd0);
        check({tag, " e2 addr"},  32'(rom_addr),  32'd2);
        tick();
        expect_pair({tag, " e3"}, 32'h0);
        check({tag, " e3 cnt"}, 32'(fq_count), 32'd1);
        tick();
        expect_pair({tag, " e4"}, 32'h8);
        tick();
        expect_pair({tag, " e5"}, 32'h10);
        tick();
        expect_pair({tag, " e6"}, 32'h18);
    endtask

    task automatic do_reset(input logic ready);
        rst_n     = 1'b0;
        dec_ready = ready;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            rom_mem[i] = rom_word(i);
        end

        // Reset values, then boot timing with decode always ready
        tick();
        tick();
        expect_idle("rst");
        check("rst addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        boot_check("boot");

        // Back-pressure from reset: queue fills to 4 and issue stalls
        do_reset(1'b0);
        repeat (8) tick();
        check("bp cnt", 32'(fq_count), 32'd4);
        expect_pair("bp head", 32'h0);
        check("bp addr", 32'(rom_addr), 32'd8);
        dec_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            expect_pair("bp drain", 32'(k * 8));
        end

        // Redirect in the same cycle as a pop: the popped entry is discarded
        pulse_redirect(32'h100);
        check("rp cnt", 32'(fq_count), 32'd0);
        check("rp v1", 32'(out_valid), 32'd0);
        tick();
        check("rp v2", 32'(out_valid), 32'd0);
        tick();
        check("rp v3", 32'(out_valid), 32'd0);
        tick();
        expect_pair("rp first", 32'h100);
        tick();
        expect_pair("rp second", 32'h108);

        // Redirect with 3 queued and one read in flight
        do_reset(1'b0);
        repeat (5) tick();
        check("fl pre cnt", 32'(fq_count), 32'd3);
        pulse_redirect(32'h43);
        check("fl cnt", 32'(fq_count), 32'd0);
        check("fl v1", 32'(out_valid), 32'd0);
        tick();
        check("fl v2", 32'(out_valid), 32'd0);
        tick();
        check("fl v3", 32'(out_valid), 32'd0);
        tick();
        expect_pair("fl target", 32'h40);
        check("fl cnt1", 32'(fq_count), 32'd1);

        // Redirect to the last ROM word: slot 2 is filler and the PC wraps to 0x004
        dec_ready = 1'b1;
        pulse_redirect(32'hFFC);
        tick();
        tick();
        tick();
        expect_pair("wrap last", 32'hFFC);
        tick();
        expect_pair("wrap next", 32'h4);

        // Asynchronous reset in mid-stream with a partly full queue
        dec_ready = 1'b0;
        tick();
        tick();
        check("ar pre valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("async rst");
        check("async rst addr", 32'(rom_addr), 32'd0);
        dec_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        boot_check("reboot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
